// File: rtl/pc_jump_unit_pkg.sv
// Core-wide defines shared by the PC/jump stage: widths, reset vector, FSM encodings.
// Optional link-register write-back is enabled by defining PC_JUMP_LINK_EN.
package pc_jump_unit_pkg;

    localparam int          PC_W          = 16;
    localparam logic [15:0] RESET_PC      = 16'h0000;
    localparam int          FLUSH_CYC_DEF = 2;
    localparam int          CNT_W         = 3;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/pc_jump_unit_target_calc.sv
// Combinational jump target: absolute or PC-relative, with relative wrap detection.
module pc_target_calc #(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_jump_off,
    input  logic            i_jump_abs,
    output logic [PC_W-1:0] o_target,
    output logic            o_wrap
);

    logic [PC_W-1:0] w_sum;

    assign w_sum    = i_pc + i_jump_off;
    assign o_target = i_jump_abs ? i_jump_off : w_sum;

    // A forward offset that lands below pc (or backward above it) wrapped the address space.
    assign o_wrap = !i_jump_abs &&
                    ((!i_jump_off[PC_W-1] && (w_sum < i_pc)) ||
                     ( i_jump_off[PC_W-1] && (w_sum > i_pc)));

endmodule

// File: rtl/pc_jump_unit.sv
// PC and jump-consumer stage: sequential fetch, taken jumps with a fixed flush window.
// Define PC_JUMP_LINK_EN to add the link-register write port (link_en/link_we/link_addr).
module pc_jump_unit
    import pc_jump_unit_pkg::*;
#(
    parameter int              PC_W      = pc_jump_unit_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC  = pc_jump_unit_pkg::RESET_PC,
    parameter int              FLUSH_CYC = FLUSH_CYC_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic            i_jump_req,
    input  logic            i_jump_abs,
    input  logic [PC_W-1:0] i_jump_off,
    output logic            o_jump_ack,
    output logic [PC_W-1:0] o_pc,
    output logic            o_pc_valid,
    output logic            o_flush,
    output logic            o_wrap_err
`ifdef PC_JUMP_LINK_EN
    ,
    input  logic            i_link_en,
    output logic            o_link_we,
    output logic [PC_W-1:0] o_link_addr
`endif
);

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [PC_W-1:0]  r_pc, w_pc_nxt;
    logic             r_pc_valid, w_pc_valid_nxt;
    logic             r_flush, w_flush_nxt;
    logic             r_ack, w_ack_nxt;
    logic             r_wrap, w_wrap_nxt;

    logic [PC_W-1:0]  w_target;
    logic             w_wrap;
    logic             w_take;

    pc_target_calc #(.PC_W(PC_W)) u_calc (
        .i_pc       (r_pc),
        .i_jump_off (i_jump_off),
        .i_jump_abs (i_jump_abs),
        .o_target   (w_target),
        .o_wrap     (w_wrap)
    );

    assign w_take = (r_state == ST_RUN) && !i_stall && i_jump_req;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_RUN;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (w_take) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (r_cnt == '0) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_pc_nxt       = r_pc;
        w_pc_valid_nxt = r_pc_valid;
        w_flush_nxt    = r_flush;
        w_ack_nxt      = 1'b0;
        w_wrap_nxt     = r_wrap;
        case (r_state)
            ST_RUN: begin
                if (w_take) begin
                    w_pc_nxt       = w_target;
                    w_ack_nxt      = 1'b1;
                    w_flush_nxt    = 1'b1;
                    w_pc_valid_nxt = 1'b0;
                    w_cnt_nxt      = CNT_W'(FLUSH_CYC - 1);
                    w_wrap_nxt     = r_wrap | w_wrap;
                end else begin
                    // First valid cycle (after reset) presents pc unchanged; advance afterwards.
                    if (!i_stall && r_pc_valid) w_pc_nxt = r_pc + 1'b1;
                    w_pc_valid_nxt = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (r_cnt == '0) begin
                    w_pc_valid_nxt = 1'b1;
                    w_flush_nxt    = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b0;
            r_ack      <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_pc       <= w_pc_nxt;
            r_pc_valid <= w_pc_valid_nxt;
            r_flush    <= w_flush_nxt;
            r_ack      <= w_ack_nxt;
            r_wrap     <= w_wrap_nxt;
        end
    end

    assign o_jump_ack = r_ack;
    assign o_pc       = r_pc;
    assign o_pc_valid = r_pc_valid;
    assign o_flush    = r_flush;
    assign o_wrap_err = r_wrap;

`ifdef PC_JUMP_LINK_EN
    logic            r_link_we;
    logic [PC_W-1:0] r_link_addr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_link_we   <= 1'b0;
            r_link_addr <= '0;
        end else begin
            r_link_we <= w_take && i_link_en;
            if (w_take && i_link_en) r_link_addr <= r_pc + 1'b1;
        end
    end

    assign o_link_we   = r_link_we;
    assign o_link_addr = r_link_addr;
`endif

endmodule

// File: tb/tb_pc_jump_unit.sv
// Directed self-checking bench for pc_jump_unit (default FLUSH_CYC=2).
// Link-port checks are compiled in when PC_JUMP_LINK_EN is defined.
module tb_pc_jump_unit;

    logic        clk = 1'b0;
    logic        rst_n, stall, jump_req, jump_abs;
    logic [15:0] jump_off;
    logic        jump_ack, pc_valid, flush, wrap_err;
    logic [15:0] pc;
`ifdef PC_JUMP_LINK_EN
    logic        link_en, link_we;
    logic [15:0] link_addr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_jump_unit dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_stall    (stall),
        .i_jump_req (jump_req),
        .i_jump_abs (jump_abs),
        .i_jump_off (jump_off),
        .o_jump_ack (jump_ack),
        .o_pc       (pc),
        .o_pc_valid (pc_valid),
        .o_flush    (flush),
        .o_wrap_err (wrap_err)
`ifdef PC_JUMP_LINK_EN
        ,
        .i_link_en  (link_en),
        .o_link_we  (link_we),
        .o_link_addr(link_addr)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pc, pc_valid, flush, jump_ack in one call
    task automatic chk4(input string tag, input logic [15:0] epc, input logic ev,
                        input logic ef, input logic ea);
        chk({tag, ".pc"}, {16'h0, pc}, {16'h0, epc});
        chk({tag, ".valid"}, {31'h0, pc_valid}, {31'h0, ev});
        chk({tag, ".flush"}, {31'h0, flush}, {31'h0, ef});
        chk({tag, ".ack"}, {31'h0, jump_ack}, {31'h0, ea});
    endtask

    task automatic req(input logic abs_i, input logic [15:0] off_i);
        jump_req = 1'b1;
        jump_abs = abs_i;
        jump_off = off_i;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; jump_req = 1'b0; jump_abs = 1'b0; jump_off = 16'h0;
`ifdef PC_JUMP_LINK_EN
        link_en = 1'b0;
`endif
        tick(); tick();
        chk4("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("rst.wrap", {31'h0, wrap_err}, 32'h0);

        // free run: first edge after release keeps pc, then increments
        rst_n = 1'b1;
        tick(); chk4("run0", 16'h0000, 1'b1, 1'b0, 1'b0);
        tick(); chk4("run1", 16'h0001, 1'b1, 1'b0, 1'b0);
        tick(); chk4("run2", 16'h0002, 1'b1, 1'b0, 1'b0);
        tick(); chk4("run3", 16'h0003, 1'b1, 1'b0, 1'b0);

        // absolute jump to 0010 to set up the relative test
        req(1'b1, 16'h0010);
        tick(); chk4("abs10", 16'h0010, 1'b0, 1'b1, 1'b1);
        jump_req = 1'b0;
        tick(); chk4("abs10.f2", 16'h0010, 1'b0, 1'b1, 1'b0);
        tick(); chk4("abs10.run", 16'h0010, 1'b1, 1'b0, 1'b0);

        // relative backward jump 0010 + FFFC = 000C
        req(1'b0, 16'hFFFC);
        tick(); chk4("rel.j", 16'h000C, 1'b0, 1'b1, 1'b1);
        jump_req = 1'b0;
        tick(); chk4("rel.f2", 16'h000C, 1'b0, 1'b1, 1'b0);
        tick(); chk4("rel.run", 16'h000C, 1'b1, 1'b0, 1'b0);
        tick(); chk4("rel.inc", 16'h000D, 1'b1, 1'b0, 1'b0);
        chk("rel.wrap", {31'h0, wrap_err}, 32'h0);

        // wrap: FFFE + 0005 = 0003
        req(1'b1, 16'hFFFE);
        tick(); jump_req = 1'b0; tick(); tick();
        chk4("absFFFE", 16'hFFFE, 1'b1, 1'b0, 1'b0);
        req(1'b0, 16'h0005);
        tick(); chk4("wrap.j", 16'h0003, 1'b0, 1'b1, 1'b1);
        chk("wrap.set", {31'h0, wrap_err}, 32'h1);
        jump_req = 1'b0;
        tick(); tick();
        chk4("wrap.run", 16'h0003, 1'b1, 1'b0, 1'b0);

        // stall beats a pending jump
        stall = 1'b1;
        req(1'b0, 16'h0010);
        for (int i = 0; i < 4; i++) begin
            tick(); chk4("stall", 16'h0003, 1'b1, 1'b0, 1'b0);
        end
        stall = 1'b0;
        tick(); chk4("stall.rel", 16'h0013, 1'b0, 1'b1, 1'b1);
        chk("wrap.sticky", {31'h0, wrap_err}, 32'h1);

        // absolute request during FLUSH waits for RUN
        req(1'b1, 16'h1234);
        tick(); chk4("fl.req1", 16'h0013, 1'b0, 1'b1, 1'b0);
        tick(); chk4("fl.req2", 16'h0013, 1'b1, 1'b0, 1'b0);
        tick(); chk4("fl.take", 16'h1234, 1'b0, 1'b1, 1'b1);
        chk("wrap.sticky2", {31'h0, wrap_err}, 32'h1);

        // reset in the second FLUSH cycle, with a request still pending
        tick(); chk4("fl2", 16'h1234, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick(); chk4("midrst", 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("midrst.wrap", {31'h0, wrap_err}, 32'h0);
        rst_n = 1'b1;
        jump_req = 1'b0;
        tick(); chk4("midrst.run", 16'h0000, 1'b1, 1'b0, 1'b0);

        // relative self-loop still flushes
        req(1'b0, 16'h0000);
        tick(); chk4("self", 16'h0000, 1'b0, 1'b1, 1'b1);
        chk("self.wrap", {31'h0, wrap_err}, 32'h0);
        jump_req = 1'b0;
        tick(); tick();
        chk4("self.run", 16'h0000, 1'b1, 1'b0, 1'b0);

        // sequential FFFF -> 0000 is silent
        req(1'b1, 16'hFFFF);
        tick(); jump_req = 1'b0; tick(); tick();
        chk4("seq.FFFF", 16'hFFFF, 1'b1, 1'b0, 1'b0);
        tick(); chk4("seq.0000", 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("seq.wrap", {31'h0, wrap_err}, 32'h0);

`ifdef PC_JUMP_LINK_EN
        chk("link.rst", {15'h0, link_we, link_addr}, 32'h0);
        req(1'b1, 16'h0040);
        tick(); jump_req = 1'b0; tick(); tick();
        chk4("link.pc40", 16'h0040, 1'b1, 1'b0, 1'b0);
        link_en = 1'b1;
        req(1'b0, 16'h0010);
        tick(); chk4("link.j", 16'h0050, 1'b0, 1'b1, 1'b1);
        chk("link.we", {31'h0, link_we}, 32'h1);
        chk("link.addr", {16'h0, link_addr}, 32'h0041);
        jump_req = 1'b0;
        link_en = 1'b0;
        tick(); chk("link.we_off", {31'h0, link_we}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
